// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with dual writeback, write-through bypass, PC alias and pending-write scoreboard
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   we_a/wa_a/wd_a           write port A (ALU writeback)
//   we_b/wa_b/wd_b           write port B (load writeback), wins address collisions
//   ra  [NRD*ADDR_W]         read addresses, port i at [i*ADDR_W +: ADDR_W]
//   pc_in                    value returned for reads of the top address
//   rd  [NRD*WIDTH]          combinational read data, port i at [i*WIDTH +: WIDTH]
//   issue_v/issue_addr       destination register of the issuing instruction
//   busy_o [NRD]             read register has an outstanding write
module reg_file_mp #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int NRD    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_a,
    input  logic [ADDR_W-1:0]     wa_a,
    input  logic [WIDTH-1:0]      wd_a,
    input  logic                  we_b,
    input  logic [ADDR_W-1:0]     wa_b,
    input  logic [WIDTH-1:0]      wd_b,
    input  logic [NRD*ADDR_W-1:0] ra,
    input  logic [WIDTH-1:0]      pc_in,
    output logic [NRD*WIDTH-1:0]  rd,
    input  logic                  issue_v,
    input  logic [ADDR_W-1:0]     issue_addr,
    output logic [NRD-1:0]        busy_o
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC = ADDR_W'(NREG - 1);
    logic [WIDTH-1:0] regs [NREG-1];
    logic [NREG-2:0]  busy;
    logic [NREG-2:0]  busy_nxt;
    logic             wr_a;
    logic             wr_b;
    logic             iss;
    always_comb begin
        wr_a = we_a && wa_a != PC;
        wr_b = we_b && wa_b != PC;
        iss  = issue_v && issue_addr != PC;
    end
    // Clears first, then the issue set so a new producer supersedes a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (wr_a) busy_nxt[wa_a] = 1'b0;
        if (wr_b) busy_nxt[wa_b] = 1'b0;
        if (iss) busy_nxt[issue_addr] = 1'b1;
    end
    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG - 1; k++) regs[k] <= '0;
            busy <= '0;
        end else begin
            if (wr_a) regs[wa_a] <= wd_a;
            if (wr_b) regs[wa_b] <= wd_b;
            busy <= busy_nxt;
        end
    end
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              byp_a;
        logic              byp_b;
        always_comb begin
            a     = ra[i*ADDR_W +: ADDR_W];
            byp_a = !rst && we_a && wa_a == a;
            byp_b = !rst && we_b && wa_b == a;
            rd[i*WIDTH +: WIDTH] = a == PC ? pc_in : byp_b ? wd_b : byp_a ? wd_a : regs[a];
            busy_o[i] = !rst && a != PC && !byp_a && !byp_b && busy[a];
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic        we_a, we_b, issue_v;
    logic [3:0]  wa_a, wa_b, issue_addr;
    logic [31:0] wd_a, wd_b, pc_in;
    logic [11:0] ra;
    logic [95:0] rd;
    logic [2:0]  busy_o;
    int checks = 0;
    int errors = 0;
    typedef struct {
        string       tag;
        bit          is_busy;
        int          port;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    reg_file_mp #(.WIDTH(32), .ADDR_W(4), .NRD(3)) dut (
        .clk(clk), .rst(rst),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .ra(ra), .pc_in(pc_in), .rd(rd),
        .issue_v(issue_v), .issue_addr(issue_addr), .busy_o(busy_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_ra(input int p, input logic [3:0] a);
        ra[p*4 +: 4] = a;
    endtask
    task automatic exp_rd(input string tag, input int p, input logic [31:0] v);
        sb.push_back('{tag, 1'b0, p, v});
    endtask
    task automatic exp_busy(input string tag, input int p, input logic v);
        sb.push_back('{tag, 1'b1, p, {31'b0, v}});
    endtask
    task automatic settle();
        exp_t e;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, e.is_busy ? {31'b0, busy_o[e.port]} : rd[e.port*32 +: 32], e.val);
        end
    endtask
    initial begin
        rst = 1'b1; we_a = 0; we_b = 0; issue_v = 0;
        wa_a = 0; wa_b = 0; issue_addr = 0;
        wd_a = 0; wd_b = 0; pc_in = 0; ra = 0;
        tick();
        rst = 1'b0;
        for (int p = 0; p < 3; p++) set_ra(p, 4'd5);
        for (int p = 0; p < 3; p++) begin
            exp_rd("reset_rd", p, 32'h0);
            exp_busy("reset_busy", p, 1'b0);
        end
        settle();
        for (int r = 0; r < 15; r++) begin
            we_a = 1; wa_a = 4'(r); wd_a = 32'(r) * 32'h01010101;
            tick();
            we_a = 0;
            for (int p = 0; p < 3; p++) begin
                set_ra(p, 4'(r));
                exp_rd("wr_rd", p, 32'(r) * 32'h01010101);
            end
            settle();
        end
        we_a = 1; wa_a = 4'd15; wd_a = 32'hDEADBEEF; pc_in = 32'h00000108;
        set_ra(0, 4'd15);
        exp_rd("pc_during_write", 0, 32'h00000108);
        settle();
        tick();
        we_a = 0;
        set_ra(1, 4'd14);
        exp_rd("pc_read", 0, 32'h00000108);
        exp_rd("r14_intact", 1, 32'h0E0E0E0E);
        settle();
        we_a = 1; wa_a = 4'd3; wd_a = 32'h11111111;
        we_b = 1; wa_b = 4'd3; wd_b = 32'h22222222;
        set_ra(0, 4'd3);
        exp_rd("collide_bypass", 0, 32'h22222222);
        settle();
        tick();
        we_a = 0; we_b = 0;
        exp_rd("collide_stored", 0, 32'h22222222);
        settle();
        we_a = 1; wa_a = 4'd4; wd_a = 32'hAAAA5555;
        set_ra(1, 4'd4);
        exp_rd("bypass_a", 1, 32'hAAAA5555);
        settle();
        tick();
        we_a = 0;
        issue_v = 1; issue_addr = 4'd7;
        tick();
        issue_v = 0;
        for (int p = 0; p < 3; p++) begin
            set_ra(p, 4'd7);
            exp_busy("issue_busy", p, 1'b1);
        end
        exp_rd("issue_rd_old", 0, 32'h07070707);
        settle();
        tick();
        we_b = 1; wa_b = 4'd7; wd_b = 32'h00000077;
        exp_busy("wb_bypass_busy", 0, 1'b0);
        exp_rd("wb_bypass_rd", 0, 32'h00000077);
        settle();
        tick();
        we_b = 0;
        exp_busy("wb_after_busy", 0, 1'b0);
        exp_rd("wb_after_rd", 0, 32'h00000077);
        settle();
        we_a = 1; wa_a = 4'd9; wd_a = 32'h99999999;
        issue_v = 1; issue_addr = 4'd9;
        tick();
        we_a = 0; issue_v = 0;
        set_ra(0, 4'd9);
        exp_busy("set_wins_busy", 0, 1'b1);
        exp_rd("set_wins_rd", 0, 32'h99999999);
        settle();
        we_a = 1; wa_a = 4'd2; wd_a = 32'h12345678;
        issue_v = 1; issue_addr = 4'd2;
        tick();
        we_a = 0; issue_v = 0;
        set_ra(0, 4'd2);
        exp_busy("pre_rst_busy", 0, 1'b1);
        exp_rd("pre_rst_rd", 0, 32'h12345678);
        settle();
        rst = 1; we_a = 1; wa_a = 4'd2; wd_a = 32'hFFFFFFFF;
        exp_rd("in_rst_no_bypass", 0, 32'h12345678);
        exp_busy("in_rst_busy", 0, 1'b0);
        settle();
        tick();
        rst = 0; we_a = 0;
        set_ra(1, 4'd9);
        set_ra(2, 4'd15);
        exp_rd("post_rst_r2", 0, 32'h0);
        exp_busy("post_rst_busy", 0, 1'b0);
        exp_rd("post_rst_r9", 1, 32'h0);
        exp_busy("post_rst_busy9", 1, 1'b0);
        exp_rd("post_rst_pc", 2, 32'h00000108);
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the pipelined core; successor to the single-write, dual-read register file.
- Provides NRD combinational read ports and two synchronous write ports: port A for ALU writeback, port B for load writeback.
- Provides write-through bypass, a PC (top register) read override, and a per-register pending-write scoreboard used by hazard detection.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
WIDTH, 32, data width of each register
ADDR_W, 4, register address width; NREG = 2**ADDR_W registers, top index NREG-1 is the PC alias
NRD, 3, number of read ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
we_a  in  1  write enable, port A
wa_a  in  ADDR_W  write address, port A
wd_a  in  WIDTH  write data, port A
we_b  in  1  write enable, port B
wa_b  in  ADDR_W  write address, port B
wd_b  in  WIDTH  write data, port B
ra  in  NRD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W]
pc_in  in  WIDTH  value returned for reads of address NREG-1
rd  out  NRD*WIDTH  read data; port i uses slice [i*WIDTH +: WIDTH]
issue_v  in  1  an instruction with register destination issues this cycle
issue_addr  in  ADDR_W  destination register of the issuing instruction
busy_o  out  NRD  busy_o[i]=1: register ra[i] has an outstanding write

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Storage: regs[0..NREG-2] plus busy[0..NREG-2]. The PC alias has no storage.
- Reset: on the rising edge with rst=1:
  - all regs become 0 and all busy bits become 0;
  - writes and issues in that cycle are ignored.
  - From the next cycle, all rd slices read 0 (except the PC address, which reads pc_in) and busy_o = 0.
- Write timing: on the rising edge with rst=0, regs[wa_x] <= wd_x when we_x=1. Writes addressed to NREG-1 are dropped.
- Write collision: we_a=we_b=1 with wa_a==wa_b means port B wins. Port A data is discarded.
- Read, zero latency, combinational, evaluated per port with this priority:
  1. ra[i]==NREG-1 returns pc_in.
  2. rst=0, we_b=1 and wa_b==ra[i] returns wd_b (bypass).
  3. rst=0, we_a=1 and wa_a==ra[i] returns wd_a (bypass).
  4. Otherwise returns regs[ra[i]].
- Bypass is therefore same-cycle write-through. A value written at edge N is also returned from storage after edge N.
- Scoreboard, updated on rising edge with rst=0:
  - clear busy[wa_a] if we_a; clear busy[wa_b] if we_b;
  - then set busy[issue_addr] if issue_v.
  - Set wins over a clear of the same register in the same cycle (a new producer supersedes the retiring one).
  - Issue to NREG-1 is ignored.
- busy_o[i] = busy[ra[i]] AND NOT (a write to ra[i] is being bypassed this cycle). Forced 0 for ra[i]==NREG-1 and while rst=1.
- Multiple read ports may address the same register. Each port returns an identical value.
- No registered outputs. rd and busy_o settle within the cycle of the address change.

Test Plan:
- Reset then read: assert rst for 1 cycle, set all ra to 5 -> every rd slice = 0x00000000, busy_o = 0.
- Basic write/read across all registers: for r=0..14, write r*0x01010101 via port A, then read on all NRD ports -> each rd slice = r*0x01010101. Write to 15 with wd_a=0xDEADBEEF, pc_in=0x00000108 -> read 15 returns 0x00000108.
- Bypass and collision:
  - we_a=1, wa_a=3, wd_a=0x11111111 and we_b=1, wa_b=3, wd_b=0x22222222, with ra0=3 -> rd0=0x22222222 in the same cycle.
  - After the edge, with both writes off -> rd0=0x22222222.
  - Port A alone to R4 with 0xAAAA5555, ra1=4 -> rd1=0xAAAA5555 in the same cycle.
- Scoreboard: issue_v=1, issue_addr=7 -> next cycle ra0=7 gives busy_o[0]=1. A port B write to R7 in a later cycle -> busy_o[0]=0 that cycle (bypass) and stays 0 after the edge.
- Set-vs-clear: we_a=1, wa_a=9 together with issue_v=1, issue_addr=9 on the same edge -> after the edge, busy for R9 = 1 and regs[9] = wd_a.
- Reset mid-operation: busy[2]=1 and R2=0x12345678, then rst=1 with we_a=1, wa_a=2, wd_a=0xFFFFFFFF -> after the edge, R2 reads 0 and busy_o for R2 = 0.
